mem_port_arbiter: RTL

//  Shares the CPU's single memory port between two requesters: instruction fetch (I) and

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (I) and data load/store (D); D has priority, and a streak limiter stops fetch from starving.
// Latency: accept at cycle N, m_req_val from N+1, response pulse at N+2 at the earliest (ack in N+1), or one cycle after ack/timeout.
// Backpressure: requests are accepted only in IDLE (one per cycle). Responses are single-cycle pulses that requesters must sink.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch requester
  input  logic                i_req_val,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_req_rdy,
  output logic                i_rsp_val,
  output logic [DATA_W-1:0]   i_rsp_data,
  output logic                i_rsp_err,
  // data requester
  input  logic                d_req_val,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_be,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_req_rdy,
  output logic                d_rsp_val,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                d_rsp_err,
  // memory side
  output logic                m_req_val,
  output logic                m_req_we,
  output logic [DATA_W/8-1:0] m_req_be,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic [DATA_W-1:0]   m_req_wdata,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int STRK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_D_STREAK);
  // Last timer value before the access is abandoned (unused when TIMEOUT_CYC is 0).
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STRK_W-1:0]   r_streak;
  logic [STRK_W-1:0]   w_streak_nxt;
  logic [TMR_W-1:0]    r_timer;
  logic [TMR_W-1:0]    w_timer_nxt;

  // captured request; drives the memory bus while in MEM
  logic                r_owner_d;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // response pulses
  logic                r_i_rsp_val;
  logic                r_i_rsp_err;
  logic [DATA_W-1:0]   r_i_rsp_data;
  logic                r_d_rsp_val;
  logic                r_d_rsp_err;
  logic [DATA_W-1:0]   r_d_rsp_data;

  logic                w_idle;
  logic                w_i_rdy;
  logic                w_d_rdy;
  logic                w_i_acc;
  logic                w_d_acc;
  logic                w_acc;
  logic                w_tmo;
  logic                w_done;
  logic                w_done_err;

  // Ready is held low throughout reset, not just after the reset edge.
  assign w_idle  = rst_n && (r_state == ST_IDLE);
  // D wins unless it has used up its streak while fetch is waiting.
  assign w_d_rdy = w_idle && (!i_req_val || (r_streak < STRK_MAX));
  assign w_i_rdy = w_idle && (!d_req_val || (r_streak == STRK_MAX));
  assign w_d_acc = d_req_val && w_d_rdy;
  assign w_i_acc = i_req_val && w_i_rdy;
  assign w_acc   = w_d_acc || w_i_acc;
  assign w_tmo   = (TIMEOUT_CYC != 0) && (r_timer == TMR_LAST);

  // Next-state, streak and timer update; an ack beats a timeout in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_timer_nxt  = r_timer;
    w_done       = 1'b0;
    w_done_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_state_nxt = ST_MEM;
          w_timer_nxt = '0;
          if (w_i_acc) begin
            w_streak_nxt = '0;
          end else if (i_req_val && (r_streak != STRK_MAX)) begin
            w_streak_nxt = r_streak + STRK_W'(1);
          end
        end
      end
      ST_MEM: begin
        if (m_ack) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
          w_done_err  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, streak and timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_streak <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  // Capture the granted request; fetch always reads the full word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_acc) begin
      r_owner_d <= w_d_acc;
      r_we      <= w_d_acc ? d_req_we : 1'b0;
      r_be      <= w_d_acc ? d_req_be : {BE_W{1'b1}};
      r_addr    <= w_d_acc ? d_req_addr : i_req_addr;
      r_wdata   <= w_d_acc ? d_req_wdata : '0;
    end
  end

  // One-cycle response to the owner; data is only returned for a successful read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i_rsp_val  <= 1'b0;
      r_i_rsp_err  <= 1'b0;
      r_i_rsp_data <= '0;
      r_d_rsp_val  <= 1'b0;
      r_d_rsp_err  <= 1'b0;
      r_d_rsp_data <= '0;
    end else begin
      r_i_rsp_val  <= w_done && !r_owner_d;
      r_i_rsp_err  <= w_done_err && !r_owner_d;
      r_i_rsp_data <= (w_done && !w_done_err && !r_owner_d) ? m_rdata : '0;
      r_d_rsp_val  <= w_done && r_owner_d;
      r_d_rsp_err  <= w_done_err && r_owner_d;
      r_d_rsp_data <= (w_done && !w_done_err && r_owner_d && !r_we) ? m_rdata : '0;
    end
  end

  assign i_req_rdy   = w_i_rdy;
  assign d_req_rdy   = w_d_rdy;
  assign i_rsp_val   = r_i_rsp_val;
  assign i_rsp_err   = r_i_rsp_err;
  assign i_rsp_data  = r_i_rsp_data;
  assign d_rsp_val   = r_d_rsp_val;
  assign d_rsp_err   = r_d_rsp_err;
  assign d_rsp_data  = r_d_rsp_data;
  assign m_req_val   = (r_state == ST_MEM);
  assign m_req_we    = r_we;
  assign m_req_be    = r_be;
  assign m_req_addr  = r_addr;
  assign m_req_wdata = r_wdata;

endmodule
